// File: rtl/id_scoreboard_pkg.sv
// Scoreboard types and the saturating next-count helper.
`include "core.svh"

package id_scoreboard_pkg;

    typedef struct packed {
        logic raw1;
        logic raw2;
        logic cap;
        logic waw;
    } stall_t;

    function automatic int unsigned sat_next(
        input int unsigned cnt,
        input logic        inc,
        input int unsigned dec,
        input int unsigned max
    );
        int unsigned up;
        up = cnt + {31'd0, inc};
        if (dec >= up) return 0;
        if (up - dec > max) return max;
        return up - dec;
    endfunction

endpackage

// File: rtl/core.svh
// Shared core macros: register address width and scoreboard defaults.
`ifndef CORE_SVH
`define CORE_SVH

`define REG_AW 5
`define SB_MAX_OUTST_DEFAULT 3
`define SB_NUM_WB_DEFAULT 2
`define SB_CNT_W(n) $clog2((n) + 1)

`endif

// File: rtl/id_scoreboard_sb_counter.sv
// Saturating up/down outstanding-write counter for one register.
// Optional underflow assertion enabled by COVERAGE.
module sb_counter
    import id_scoreboard_pkg::*;
#(
    parameter int MAX_OUTST = 3,
    parameter int DEC_W     = 2,
    parameter int CNT_W     = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nz_d,
    output logic             nz_q
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = '0;
        if (!clr) begin
            cnt_d = CNT_W'(sat_next(32'(cnt_q), inc, 32'(dec),
                                    MAX_OUTST));
        end
        nz_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
            nz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            nz_q  <= nz_d;
        end
    end

    assign cnt = cnt_q;

`ifdef COVERAGE
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_b)
        !(!clr && (32'(dec) > 32'(cnt_q) + 32'(inc)))
    );
`endif

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard for long-latency writes.
// Optional WAW stall term enabled by SCOREBOARD_WAW_EN.
`include "core.svh"

module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_NUM   = 32,
    parameter int NUM_WB    = `SB_NUM_WB_DEFAULT,
    parameter int MAX_OUTST = `SB_MAX_OUTST_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      chk_rs1_read,
    input  logic [`REG_AW-1:0]        chk_rs1_addr,
    input  logic                      chk_rs2_read,
    input  logic [`REG_AW-1:0]        chk_rs2_addr,
    input  logic                      chk_rd_write,
    input  logic [`REG_AW-1:0]        chk_rd_addr,
    input  logic                      chk_long,
    output logic                      sb_stall,
    input  logic                      issue_valid,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*`REG_AW-1:0] wb_addr,
    input  logic                      flush,
    output logic [REG_NUM-1:0]        sb_pending,
    output logic                      sb_busy
);

    localparam int CW = `SB_CNT_W(MAX_OUTST);
    localparam int DW = $clog2(NUM_WB + 1);

    logic [CW-1:0]      cnt [REG_NUM];
    logic [DW-1:0]      dec_cnt [REG_NUM];
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] nz_d;
    logic [REG_NUM-1:0] nz_q;
    logic [`REG_AW-1:0] wa;
    logic               busy_d;
    logic               busy_q;
    stall_t             st;

    always_comb begin
        inc_vec = '0;
        if (issue_valid && chk_long && chk_rd_write &&
            chk_rd_addr != '0) begin
            inc_vec[chk_rd_addr] = 1'b1;
        end
    end

    // Channels hitting the same register accumulate.
    always_comb begin
        wa = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            dec_cnt[r] = '0;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            wa = wb_addr[i*`REG_AW +: `REG_AW];
            if (wb_valid[i] && wa != '0) begin
                dec_cnt[wa] = dec_cnt[wa] + DW'(1);
            end
        end
    end

    assign cnt[0]  = '0;
    assign nz_d[0] = 1'b0;
    assign nz_q[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        sb_counter #(
            .MAX_OUTST (MAX_OUTST),
            .DEC_W     (DW),
            .CNT_W     (CW)
        ) u_cnt (
            .clk   (clk),
            .rst_b (rst_b),
            .clr   (flush),
            .inc   (inc_vec[r]),
            .dec   (dec_cnt[r]),
            .cnt   (cnt[r]),
            .nz_d  (nz_d[r]),
            .nz_q  (nz_q[r])
        );
    end

    always_comb begin
        st      = '0;
        st.raw1 = chk_rs1_read && chk_rs1_addr != '0 &&
                  cnt[chk_rs1_addr] != '0;
        st.raw2 = chk_rs2_read && chk_rs2_addr != '0 &&
                  cnt[chk_rs2_addr] != '0;
        st.cap  = chk_long && chk_rd_write &&
                  cnt[chk_rd_addr] == CW'(MAX_OUTST);
`ifdef SCOREBOARD_WAW_EN
        st.waw  = chk_rd_write && chk_rd_addr != '0 &&
                  cnt[chk_rd_addr] != '0;
`endif
    end

    assign sb_stall = |st;

    assign busy_d = |nz_d;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign sb_pending = nz_q;
    assign sb_busy    = busy_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard with a queued expectation monitor.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        chk_rs1_read = 1'b0;
    logic [4:0]  chk_rs1_addr = '0;
    logic        chk_rs2_read = 1'b0;
    logic [4:0]  chk_rs2_addr = '0;
    logic        chk_rd_write = 1'b0;
    logic [4:0]  chk_rd_addr = '0;
    logic        chk_long = 1'b0;
    logic        sb_stall;
    logic        issue_valid = 1'b0;
    logic [1:0]  wb_valid = '0;
    logic [9:0]  wb_addr = '0;
    logic        flush = 1'b0;
    logic [31:0] sb_pending;
    logic        sb_busy;

    typedef struct {
        string       nm;
        logic        stall;
        logic [31:0] pend;
        logic        busy;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    id_scoreboard dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .chk_rs1_read (chk_rs1_read),
        .chk_rs1_addr (chk_rs1_addr),
        .chk_rs2_read (chk_rs2_read),
        .chk_rs2_addr (chk_rs2_addr),
        .chk_rd_write (chk_rd_write),
        .chk_rd_addr  (chk_rd_addr),
        .chk_long     (chk_long),
        .sb_stall     (sb_stall),
        .issue_valid  (issue_valid),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .sb_pending   (sb_pending),
        .sb_busy      (sb_busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected in it.
    task automatic cyc(
        input logic rb,
        input logic r1r, input logic [4:0] r1,
        input logic r2r, input logic [4:0] r2,
        input logic rdw, input logic [4:0] rd,
        input logic lg, input logic iv,
        input logic [1:0] wv, input logic [4:0] a0, input logic [4:0] a1,
        input logic fl,
        input logic es, input logic [31:0] ep, input logic eb,
        input string nm
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_b        = rb;
        chk_rs1_read = r1r;
        chk_rs1_addr = r1;
        chk_rs2_read = r2r;
        chk_rs2_addr = r2;
        chk_rd_write = rdw;
        chk_rd_addr  = rd;
        chk_long     = lg;
        issue_valid  = iv;
        wb_valid     = wv;
        wb_addr      = {a1, a0};
        flush        = fl;
        e.nm    = nm;
        e.stall = es;
        e.pend  = ep;
        e.busy  = eb;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc(0, 0,0, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "rst");
        cyc(1, 0,0, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "rst_idle");
        cyc(1, 0,0, 0,0, 1,5, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss5");
        cyc(1, 1,5, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 1,32'h20,1, "raw5");
        cyc(1, 1,5, 0,0, 0,0, 0,0, 2'b01,5,0, 0, 1,32'h20,1, "nobyp5");
        cyc(1, 1,5, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "clr5");
        cyc(1, 0,0, 0,0, 1,7, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss7a");
        cyc(1, 0,0, 0,0, 1,7, 1,1, 2'b00,0,0, 0, 0,32'h80,1, "iss7b");
        cyc(1, 0,0, 0,0, 1,7, 1,1, 2'b00,0,0, 0, 0,32'h80,1, "iss7c");
        cyc(1, 0,0, 0,0, 1,7, 1,0, 2'b00,0,0, 0, 1,32'h80,1, "cap7");
        cyc(1, 0,0, 0,0, 1,7, 1,0, 2'b10,0,7, 0, 1,32'h80,1, "cap7wb");
        cyc(1, 0,0, 0,0, 1,7, 1,1, 2'b00,0,0, 0, 0,32'h80,1, "iss7d");
        cyc(1, 0,0, 1,7, 0,0, 0,0, 2'b11,7,7, 0, 1,32'h80,1, "raw7dual");
        cyc(1, 0,0, 1,7, 0,0, 0,0, 2'b01,7,0, 0, 1,32'h80,1, "raw7last");
        cyc(1, 0,0, 1,7, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "idle7");
        cyc(1, 0,0, 0,0, 1,9, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss9");
        cyc(1, 0,0, 0,0, 1,9, 1,1, 2'b01,9,0, 0, 0,32'h200,1, "iss9wb");
        cyc(1, 0,0, 0,0, 0,0, 0,0, 2'b01,9,0, 0, 0,32'h200,1, "same9");
        cyc(1, 0,0, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "idle9");
        cyc(1, 0,0, 0,0, 1,4, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss4a");
        cyc(1, 0,0, 0,0, 1,4, 1,1, 2'b00,0,0, 0, 0,32'h10,1, "iss4b");
        cyc(1, 0,0, 0,0, 0,0, 0,0, 2'b11,4,4, 0, 0,32'h10,1, "dual4");
        cyc(1, 1,4, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "dual4_done");
        cyc(1, 0,0, 0,0, 1,3, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss3");
        cyc(1, 0,0, 0,0, 1,10, 1,1, 2'b00,0,0, 0, 0,32'h8,1, "iss10");
        cyc(1, 0,0, 0,0, 1,12, 1,1, 2'b00,0,0, 1, 0,32'h408,1, "flush");
        cyc(1, 1,12, 1,3, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "post_flush");
        cyc(1, 1,0, 1,0, 1,0, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "x0_iss");
        cyc(1, 1,0, 1,0, 1,0, 1,0, 2'b01,0,0, 0, 0,32'h0,0, "x0_chk");
        cyc(1, 1,0, 1,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "x0_idle");
        cyc(1, 0,0, 0,0, 0,0, 0,0, 2'b01,6,0, 0, 0,32'h0,0, "uf6");
        cyc(1, 0,0, 0,0, 1,6, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss6");
        cyc(1, 1,6, 0,0, 0,0, 0,0, 2'b01,6,0, 0, 1,32'h40,1, "raw6");
        cyc(1, 1,6, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "idle6");
        cyc(1, 0,0, 0,0, 1,8, 1,1, 2'b00,0,0, 0, 0,32'h0,0, "iss8");
        cyc(0, 0,0, 0,0, 1,8, 1,1, 2'b01,8,0, 1, 0,32'h100,1, "rst_mid");
        cyc(1, 1,8, 0,0, 0,0, 0,0, 2'b00,0,0, 0, 0,32'h0,0, "post_rst");
        done = 1'b1;
    end

    initial begin
        exp_t e;
        while (!done || exp_q.size() != 0) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (sb_stall !== e.stall) begin
                    errors++;
                    $display("FAIL %s stall: got %b want %b",
                             e.nm, sb_stall, e.stall);
                end
                checks++;
                if (sb_pending !== e.pend) begin
                    errors++;
                    $display("FAIL %s pending: got %h want %h",
                             e.nm, sb_pending, e.pend);
                end
                checks++;
                if (sb_busy !== e.busy) begin
                    errors++;
                    $display("FAIL %s busy: got %b want %b",
                             e.nm, sb_busy, e.busy);
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
